uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares the single UART transmitter in the serial security wrapper between NUM_REQ byte producers, such as the crypto engine, the status reporter and the loopback echo.
It accepts one byte from the winning requester and launches a frame with a one-cycle start pulse. It then waits for the transmitter's done pulse, enforces an inter-frame gap, and aborts with an error pulse if the frame never completes.
It sits between the producers and uart_tx, in the clk_3125 domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 512, clocks allowed from tx_start to tx_done before abort; must exceed one 11-bit frame (297 clocks at 27 clocks/bit)
GAP_CYCLES, 27, idle clocks inserted after every frame; 0 means return directly to IDLE

Ports:
clk_3125  in  1  system clock (3.125 MHz)
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = new grants allowed; 0 = finish in-flight frame, then hold in IDLE
req_valid  in  NUM_REQ  per-requester byte-available flag
req_data  in  8*NUM_REQ  byte i on bits [8i+7:8i]
req_ready  out  NUM_REQ  one-hot, one-cycle pulse: byte of requester i was taken at the previous edge
tx_start  out  1  one-cycle pulse to uart_tx
tx_data  out  8  byte to transmit, stable from tx_start until leaving WAIT_DONE
tx_done  in  1  one-cycle pulse from uart_tx at end of stop bit
grant_id  out  clog2(NUM_REQ)  index of current/last granted requester
busy  out  1  high in every state except IDLE
timeout_err  out  1  one-cycle pulse on abort
err_count  out  8  saturating count of timeouts

Behaviour:
- Reset (rst_n low, asynchronous):
  - all outputs 0, state IDLE, counters 0
  - internal last_grant = NUM_REQ-1, so requester 0 has first priority
- Reset mid-frame: the controller returns to IDLE immediately. uart_tx is reset by the same rst_n; no stale tx_done is expected.
- States: IDLE, LAUNCH, WAIT_DONE, GAP.
- IDLE:
  - Condition: enable=1 and req_valid != 0.
  - Winner: first set bit searching upward from (last_grant+1) mod NUM_REQ, with wrap.
  - At that edge: tx_data <= winner's byte, grant_id <= winner, req_ready <= onehot(winner), state -> LAUNCH.
- LAUNCH:
  - tx_start <= 1 for exactly one cycle, timer <= 0, state -> WAIT_DONE.
  - Latency from req_valid sampled to tx_start high: 2 clocks.
- WAIT_DONE:
  - tx_done=1: last_grant <= grant_id; state -> GAP, or IDLE if GAP_CYCLES=0.
  - Else timer increments. When timer == TIMEOUT_CYCLES-1: timeout_err pulse, err_count += 1 (saturates at 255), last_grant <= grant_id, state -> GAP.
  - tx_done and timeout in the same cycle: tx_done wins, no error.
- GAP: counter runs 0..GAP_CYCLES-1, then -> IDLE. A tx_done received here is ignored.
- Requesters drop or update req_valid in the cycle after req_ready. The controller never samples req_valid outside IDLE, so a byte cannot be double-accepted.
- enable deasserted outside IDLE has no effect until the controller returns to IDLE.
- tx_data and grant_id hold their last values in IDLE.
- Counter width: clog2(max(TIMEOUT_CYCLES, GAP_CYCLES)+1).
- Fairness: with all requesters continuously valid, grants cycle 0,1,..,NUM_REQ-1,0. A requester waits at most NUM_REQ-1 frames.

Decomposition:
- Shared package uart_pkg:
  - state encoding constants: IDLE=0, LAUNCH=1, WAIT_DONE=2, GAP=3
  - CLKS_PER_BIT=27, FRAME_CLKS=297, used by uart_tx, uart_rx and this block
- Sub-module rr_pick: purely combinational. Inputs req vector and last_grant; outputs winner index and any_valid.
- FSM, timers and output registers live in uart_tx_arbiter.

Test Plan:
1. Reset, then only requester 2 valid with 0xA5, tx_done returned 297 clocks after tx_start:
   - req_ready=0b0100 one cycle; tx_start 2 clocks after req_valid sampled; tx_data=0xA5; grant_id=2
   - busy falls GAP_CYCLES+1 clocks after tx_done
2. All 4 requesters continuously valid (bytes 0x10,0x11,0x12,0x13), uart_tx model answering each frame:
   - tx_data sequence 0x10,0x11,0x12,0x13,0x10
   - each tx_start separated by at least 297+27+2 clocks
3. Requester 1 valid, tx_done never returned:
   - timeout_err pulses exactly TIMEOUT_CYCLES clocks after tx_start; err_count=1; IDLE after GAP
   - 256 such timeouts: err_count holds 255
4. tx_done pulsed on the same cycle timer reaches TIMEOUT_CYCLES-1 -> no timeout_err, err_count unchanged.
5. enable dropped during WAIT_DONE with requesters 0 and 3 valid:
   - current frame completes; no further req_ready or tx_start while enable=0
   - re-assert enable -> next grant is the round-robin successor of the previous grant
6. rst_n pulsed low mid-WAIT_DONE:
   - busy, tx_start, req_ready go 0 asynchronously; grant_id=0
   - after release, requester 0 wins first if valid

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: bit timing used by uart_tx/uart_rx and the
// transmit arbiter state encoding.
package uart_pkg;

  localparam int CLKS_PER_BIT = 27;
  localparam int FRAME_CLKS   = 297;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } arb_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit searching upward
// from last_grant+1 with wrap-around.
module rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last_grant,
  output logic [IDW-1:0]     winner,
  output logic               any_valid
);

  logic [IDW-1:0] idx;

  // Scan from the farthest candidate down so the nearest successor is written last.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IDW'((int'(last_grant) + k) % NUM_REQ);
      if (req[idx]) begin
        winner    = idx;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx between NUM_REQ byte producers:
// grant, launch, wait for done (with timeout abort), then inter-frame gap.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 512,
  parameter int GAP_CYCLES     = 27,
  localparam int IDW           = $clog2(NUM_REQ)
) (
  input  logic                   clk_3125,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  input  logic                   tx_done,
  output logic [IDW-1:0]         grant_id,
  output logic                   busy,
  output logic                   timeout_err,
  output logic [7:0]             err_count,
  output logic [1:0]             state_dbg
);

  // Handshake: req_valid is sampled only in IDLE. When requester i wins at an
  // edge, its byte is captured at that edge and req_ready[i] is high for the
  // following cycle; the producer drops or updates req_valid[i] in that cycle.

  localparam int CW = $clog2(max2(TIMEOUT_CYCLES, GAP_CYCLES) + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

  arb_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IDW-1:0]     last_q, last_d;
  logic [IDW-1:0]     grant_q, grant_d;
  logic [7:0]         data_q, data_d;
  logic [7:0]         err_q, err_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic               start_q, start_d;
  logic               tmo_q, tmo_d;
  logic [IDW-1:0]     winner;
  logic               any_valid;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr_pick (
    .req        (req_valid),
    .last_grant (last_q),
    .winner     (winner),
    .any_valid  (any_valid)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    grant_d = grant_q;
    data_d  = data_q;
    err_d   = err_q;
    ready_d = '0;
    start_d = 1'b0;
    tmo_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && any_valid) begin
          data_d  = req_data[{winner, 3'b000} +: 8];
          grant_d = winner;
          ready_d = NUM_REQ'(1) << winner;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        start_d = 1'b1;
        cnt_d   = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        // A done arriving on the timeout cycle still counts as success.
        if (tx_done) begin
          last_d  = grant_q;
          cnt_d   = '0;
          state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else if (cnt_q == TMO_LAST) begin
          tmo_d   = 1'b1;
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
          last_d  = grant_q;
          cnt_d   = '0;
          state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) state_d = IDLE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_3125 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= IDW'(NUM_REQ - 1);
      grant_q <= '0;
      data_q  <= '0;
      err_q   <= '0;
      ready_q <= '0;
      start_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      start_q <= start_d;
      tmo_q   <= tmo_d;
    end
  end

  assign req_ready   = ready_q;
  assign tx_start    = start_q;
  assign tx_data     = data_q;
  assign grant_id    = grant_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = tmo_q;
  assign err_count   = err_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed plus randomized checks of uart_tx_arbiter against a frame-level
// round-robin model; a second small instance exercises err_count saturation.
module tb_uart_tx_arbiter;

  localparam int NR  = 4;
  localparam int T   = 512;
  localparam int GP  = 27;
  localparam int FRM = 297;

  logic            clk_3125 = 1'b0;
  logic            rst_n;
  logic            enable;
  logic [NR-1:0]   req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic            tx_done;
  logic [1:0]      grant_id;
  logic            busy;
  logic            timeout_err;
  logic [7:0]      err_count;
  logic [1:0]      state_dbg;

  logic            rst_b_n;
  logic [1:0]      req_ready_b;
  logic            tx_start_b;
  logic [7:0]      tx_data_b;
  logic            grant_id_b;
  logic            busy_b;
  logic            timeout_err_b;
  logic [7:0]      err_count_b;
  logic [1:0]      state_dbg_b;

  int vec = 0;
  int miscomp = 0;
  int cyc = 0;
  int last_m = NR - 1;
  int err_m = 0;
  int start_q[$];

  always #5 clk_3125 = ~clk_3125;

  uart_tx_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(T), .GAP_CYCLES(GP)) dut (
    .clk_3125 (clk_3125), .rst_n (rst_n), .enable (enable),
    .req_valid (req_valid), .req_data (req_data), .req_ready (req_ready),
    .tx_start (tx_start), .tx_data (tx_data), .tx_done (tx_done),
    .grant_id (grant_id), .busy (busy), .timeout_err (timeout_err),
    .err_count (err_count), .state_dbg (state_dbg)
  );

  uart_tx_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(16), .GAP_CYCLES(0)) dut_b (
    .clk_3125 (clk_3125), .rst_n (rst_b_n), .enable (1'b1),
    .req_valid (2'b10), .req_data (16'h5A00), .req_ready (req_ready_b),
    .tx_start (tx_start_b), .tx_data (tx_data_b), .tx_done (1'b0),
    .grant_id (grant_id_b), .busy (busy_b), .timeout_err (timeout_err_b),
    .err_count (err_count_b), .state_dbg (state_dbg_b)
  );

  task automatic tick();
    @(posedge clk_3125);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miscomp++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: nearest requester above the last grant, wrapping around.
  function automatic int rr_next(input logic [NR-1:0] m, input int last);
    int idx;
    for (int k = 1; k <= NR; k++) begin
      idx = (last + k) % NR;
      if (((m >> idx) & NR'(1)) != '0) return idx;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    enable = 1'b1;
    req_valid = '0;
    req_data = '0;
    tx_done = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    last_m = NR - 1;
    err_m = 0;
    tick();
  endtask

  // One frame from grant to return to IDLE. done_delay < 0 means uart_tx never answers.
  task automatic serve_frame(input int exp_id, input int done_delay,
                             input logic [NR-1:0] nv, input logic [8*NR-1:0] nd,
                             input bit drop_en, output int waited);
    logic [7:0] exp_b;
    logic [NR-1:0] oh;
    int t;
    bit bad;
    exp_b = 8'(req_data >> (8 * exp_id));
    oh = '0;
    oh[exp_id] = 1'b1;
    waited = 0;
    while (req_ready == '0 && waited < 700) begin
      tick();
      waited++;
    end
    chk("req_ready", 32'(req_ready), 32'(oh));
    chk("grant_id", 32'(grant_id), exp_id);
    chk("tx_data", 32'(tx_data), 32'(exp_b));
    req_valid = nv;
    req_data = nd;
    tick();
    chk("tx_start_hi", 32'(tx_start), 1);
    chk("req_ready_pulse", 32'(req_ready), 0);
    start_q.push_back(cyc);
    if (drop_en) enable = 1'b0;
    tick();
    chk("tx_start_lo", 32'(tx_start), 0);
    t = 1;
    bad = 0;
    if (done_delay >= 0) begin
      while (t < done_delay) begin
        if (timeout_err !== 1'b0 || tx_data !== exp_b || tx_start !== 1'b0) bad = 1;
        tick();
        t++;
      end
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      chk("no_timeout", 32'(timeout_err), 0);
      chk("err_hold", 32'(err_count), err_m);
    end else begin
      while (timeout_err !== 1'b1 && t < T + 50) begin
        if (tx_data !== exp_b) bad = 1;
        tick();
        t++;
      end
      err_m = (err_m < 255) ? err_m + 1 : 255;
      chk("timeout_latency", t, T);
      chk("err_count", 32'(err_count), err_m);
    end
    last_m = exp_id;
    chk("tx_data_stable", 32'(bad), 0);
    tick();
    chk("tmo_pulse_width", 32'(timeout_err), 0);
    repeat (GP - 2) tick();
    chk("busy_in_gap", 32'(busy), 1);
    tick();
    chk("busy_fall", 32'(busy), 0);
    chk("grant_hold", 32'(grant_id), exp_id);
  endtask

  initial begin
    int w, e;
    logic [NR-1:0] cur_m, nxt_m;
    logic [8*NR-1:0] nxt_d;
    int dd;

    rst_b_n = 1'b0;
    do_reset();
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_timeout", 32'(timeout_err), 0);
    chk("rst_err_count", 32'(err_count), 0);
    chk("rst_state", 32'(state_dbg), 0);

    // Single requester 2 with 0xA5, answered after one frame time.
    req_valid = 4'b0100;
    req_data = 32'h00A5_0000;
    serve_frame(rr_next(req_valid, last_m), FRM, '0, req_data, 0, w);
    chk("launch_latency", w, 1);
    chk("t1_grant", 32'(grant_id), 2);

    // All requesters continuously valid: strict rotation.
    do_reset();
    start_q.delete();
    req_valid = 4'b1111;
    req_data = 32'h1312_1110;
    for (int i = 0; i < 5; i++) begin
      e = rr_next(req_valid, last_m);
      serve_frame(e, FRM, (i == 4) ? 4'b0000 : 4'b1111, req_data, 0, w);
      chk("rotation_id", e, i % NR);
    end
    for (int i = 1; i < start_q.size(); i++)
      chk("start_spacing", 32'(start_q[i] - start_q[i-1] >= FRM + GP + 2), 1);

    // Timeout with no done, then done exactly on the timeout cycle.
    req_valid = 4'b0010;
    req_data = 32'h0000_3C00;
    serve_frame(rr_next(req_valid, last_m), -1, 4'b0010, req_data, 0, w);
    serve_frame(rr_next(req_valid, last_m), T - 1, '0, req_data, 0, w);

    // enable dropped in WAIT_DONE: frame finishes, nothing new until re-enabled.
    req_valid = 4'b1001;
    req_data = 32'h7700_0066;
    serve_frame(rr_next(req_valid, last_m), 150, 4'b1001, req_data, 1, w);
    e = 0;
    repeat (60) begin
      tick();
      if (req_ready !== '0 || tx_start !== 1'b0 || busy !== 1'b0) e = 1;
    end
    chk("enable_hold", e, 0);
    enable = 1'b1;
    serve_frame(rr_next(req_valid, last_m), 120, '0, req_data, 0, w);
    chk("enable_successor", 32'(grant_id), 0);

    // Randomized masks, data and uart_tx response times.
    cur_m = NR'($urandom_range(1, 15));
    req_valid = cur_m;
    req_data = $urandom;
    for (int i = 0; i < 12; i++) begin
      nxt_m = (i == 11) ? '0 : NR'($urandom_range(1, 15));
      nxt_d = $urandom;
      case ($urandom_range(0, 7))
        0:       dd = -1;
        1:       dd = T - 1;
        default: dd = int'($urandom_range(2, 400));
      endcase
      serve_frame(rr_next(cur_m, last_m), dd, nxt_m, nxt_d, 0, w);
      cur_m = nxt_m;
    end

    // Asynchronous reset in the middle of WAIT_DONE.
    req_valid = 4'b0110;
    req_data = 32'h0044_3300;
    e = rr_next(req_valid, last_m);
    w = 0;
    while (req_ready == '0 && w < 700) begin
      tick();
      w++;
    end
    chk("pre_rst_grant", 32'(grant_id), e);
    req_valid = '0;
    repeat (12) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_tx_start", 32'(tx_start), 0);
    chk("arst_req_ready", 32'(req_ready), 0);
    chk("arst_grant", 32'(grant_id), 0);
    req_valid = 4'b1111;
    req_data = 32'hDDCC_BBAA;
    last_m = NR - 1;
    err_m = 0;
    #2 rst_n = 1'b1;
    serve_frame(rr_next(req_valid, last_m), 200, '0, req_data, 0, w);
    chk("post_rst_first", 32'(grant_id), 0);

    // err_count saturation on a short-timeout, zero-gap instance.
    rst_b_n = 1'b1;
    for (int n = 1; n <= 256; n++) begin
      w = 0;
      while (timeout_err_b !== 1'b1 && w < 40) begin
        tick();
        w++;
      end
      chk("b_timeout_seen", 32'(timeout_err_b), 1);
      chk("b_err_count", 32'(err_count_b), (n > 255) ? 255 : n);
      if (n == 1) begin
        chk("b_gap0_idle", 32'(busy_b), 0);
        chk("b_grant", 32'(grant_id_b), 1);
        chk("b_tx_data", 32'(tx_data_b), 32'h5A);
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, miscomp);
    $finish;
  end

endmodule
